// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard sequencer
package pipe_pkg;
  localparam int REG_W = 4;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} hz_state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
    logic memwb_bubble;
  } stall_ctrl_t;

  localparam stall_ctrl_t CTRL_RESET  = 6'b001101;
  localparam stall_ctrl_t CTRL_RUN    = 6'b110000;
  localparam stall_ctrl_t CTRL_MEM    = 6'b000011;
  localparam stall_ctrl_t CTRL_FLUSH  = 6'b111100;
  localparam stall_ctrl_t CTRL_BUBBLE = 6'b000100;
endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and dmem-wait detection
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mr,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_mr,
  input  logic             exmem_mw,
  input  logic             dmem_ready,
  output logic             load_use,
  output logic             mem_stall
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use  = idex_mr && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign mem_stall = (exmem_mr || exmem_mw) && !dmem_ready;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int REG_W     = pipe_pkg::REG_W,
  parameter int MEM_TMO   = 15,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ifid_halt,
  input  logic             idex_mr,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_mr,
  input  logic             exmem_mw,
  input  logic             dmem_ready,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             memwb_bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipe_pkg::*;

  localparam int DRW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  hz_state_e   state;
  logic [DRW-1:0] drain_cnt;
  logic [7:0]  wait_cnt;
  logic        load_use;
  logic        mem_stall;
  logic        halt_accept;
  stall_ctrl_t ctrl;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_mr      (idex_mr),
    .idex_rt      (idex_rt),
    .exmem_mr     (exmem_mr),
    .exmem_mw     (exmem_mw),
    .dmem_ready   (dmem_ready),
    .load_use     (load_use),
    .mem_stall    (mem_stall)
  );

  assign halt_accept = (state == RUN) && !mem_stall && !br_taken && !load_use && ifid_halt;

  // Outputs follow reset combinationally so the pipe is quiesced the instant rst_n drops
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (state != RUN) begin
      ctrl              = CTRL_BUBBLE;
      ctrl.pipe_hold    = mem_stall;
      ctrl.memwb_bubble = mem_stall;
    end else if (mem_stall) begin
      ctrl = CTRL_MEM;
    end else if (br_taken) begin
      ctrl = CTRL_FLUSH;
    end else if (load_use || ifid_halt) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign pipe_hold    = ctrl.pipe_hold;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign halted       = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (mem_stall) begin
        if (wait_cnt != 8'hff) wait_cnt <= wait_cnt + 8'd1;
        if (({1'b0, wait_cnt} + 9'd1) >= 9'(MEM_TMO)) mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if ((state == RUN) && !ctrl.pc_we && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      case (state)
        RUN: begin
          if (halt_accept) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            if (drain_cnt == DRW'(DRAIN_CYC - 1)) state <= HALTED;
            else drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end
endmodule
